// File: rtl/music_sched_pkg.sv
// Shared definitions for the music voice scheduler: frame field layout,
// frame type and decode FSM state enums.
package music_sched_pkg;

    localparam int FRAME_W            = 16;
    localparam int VOICE_MSB          = 15;
    localparam int VOICE_LSB          = 14;
    localparam int TYPE_BIT           = 13;
    localparam int PAYLOAD_W          = 13;
    localparam int AMP_W              = 8;
    localparam int VOICE_W            = VOICE_MSB - VOICE_LSB + 1;
    localparam int NUM_VOICES_DEFAULT = 4;

    typedef enum logic {
        FRAME_FREQ = 1'b0,
        FRAME_AMP  = 1'b1
    } frame_type_e;

    typedef enum logic [1:0] {
        S_IDLE,
        S_READ,
        S_WRITE
    } state_e;

    typedef struct packed {
        logic [VOICE_W-1:0]   voice;
        frame_type_e          ftype;
        logic [PAYLOAD_W-1:0] payload;
    } frame_t;

endpackage

// File: rtl/music_sched_fifo.sv
// Synchronous frame FIFO with registered read data; pointers carry an extra
// wrap bit so full and empty come straight from pointer comparison.
module music_sched_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty   = (wr_ptr == rd_ptr);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // NOTE: the storage array is deliberately not reset; the pointers alone say which entries are valid.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr[AW-1:0]] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            pop_data <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr   <= rd_ptr + 1'b1;
                pop_data <= mem[rd_ptr[AW-1:0]];
            end
        end
    end

endmodule

// File: rtl/music_voice_scheduler.sv
// Buffers SPI control frames, decodes them into shadow voice registers and commits
// them on the sample tick. Define MUSIC_SCHED_FADE_EN to fade amplitudes on link timeout.
module music_voice_scheduler
    import music_sched_pkg::*;
#(
    parameter int NUM_VOICES     = NUM_VOICES_DEFAULT,
    parameter int FIFO_DEPTH     = 8,
    parameter int WATCHDOG_TICKS = 32000
) (
    input  logic                                  CLK_50Mhz,
    input  logic                                  reset,
    input  logic                                  frame_valid,
    input  logic [FRAME_W-1:0]                    frame_data,
    output logic                                  frame_ready,
    input  logic                                  sample_tick,
    output logic [NUM_VOICES-1:0][PAYLOAD_W-1:0]  voice_freq,
    output logic [NUM_VOICES-1:0][AMP_W-1:0]      voice_amp,
    output logic                                  update_strobe,
    output logic                                  link_active,
    output logic [7:0]                            drop_count
);

    localparam int              WD_W     = $clog2(WATCHDOG_TICKS + 1);
    localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(WATCHDOG_TICKS);

    state_e                               state_q;
    state_e                               state_d;
    frame_t                               head;
    logic                                 fifo_pop;
    logic                                 fifo_full;
    logic                                 fifo_empty;
    logic                                 accept;
    logic                                 refuse;
    logic                                 shadow_wr;
    logic                                 timeout;
    logic [WD_W-1:0]                      wd_cnt;
    logic [NUM_VOICES-1:0][PAYLOAD_W-1:0] shadow_freq;
    logic [NUM_VOICES-1:0][AMP_W-1:0]     shadow_amp;

    assign frame_ready = !fifo_full && !reset;
    assign accept      = frame_valid && frame_ready;
    assign refuse      = frame_valid && !frame_ready;
    assign timeout     = (wd_cnt == WD_LIMIT);

    music_sched_fifo #(
        .WIDTH (FRAME_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (CLK_50Mhz),
        .reset     (reset),
        .push      (accept),
        .push_data (frame_data),
        .pop       (fifo_pop),
        .pop_data  (head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    always_ff @(posedge CLK_50Mhz) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: every output of this block is given a default first so no path can infer a latch.
    always_comb begin
        state_d   = state_q;
        fifo_pop  = 1'b0;
        shadow_wr = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    state_d  = S_READ;
                end
            end
            S_READ:  state_d = S_WRITE;
            S_WRITE: begin
                shadow_wr = 1'b1;
                state_d   = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Voice indices with no matching slot simply fall through the loop and are discarded.
    always_ff @(posedge CLK_50Mhz) begin
        if (reset) begin
            shadow_freq <= '0;
            shadow_amp  <= '0;
        end else begin
            for (int v = 0; v < NUM_VOICES; v++) begin
                if (shadow_wr && int'(head.voice) == v) begin
                    if (head.ftype == FRAME_FREQ) begin
                        shadow_freq[v] <= head.payload;
                    end else begin
                        shadow_amp[v] <= head.payload[AMP_W-1:0];
                    end
                end
`ifdef MUSIC_SCHED_FADE_EN
                if (timeout && sample_tick && !accept && shadow_amp[v] != '0) begin
                    shadow_amp[v] <= shadow_amp[v] - 1'b1;
                end
`else
                if (timeout) begin
                    shadow_amp[v] <= '0;
                end
`endif
            end
        end
    end

    // NOTE: non-blocking assignments make the commit see shadow values from the start of the cycle,
    // so a shadow write landing on a tick edge is picked up by the following tick.
    always_ff @(posedge CLK_50Mhz) begin
        if (reset) begin
            voice_freq    <= '0;
            voice_amp     <= '0;
            update_strobe <= 1'b0;
        end else begin
            update_strobe <= sample_tick;
            if (sample_tick) begin
                voice_freq <= shadow_freq;
                voice_amp  <= shadow_amp;
            end
        end
    end

    always_ff @(posedge CLK_50Mhz) begin
        if (reset) begin
            wd_cnt      <= '0;
            link_active <= 1'b0;
        end else if (accept) begin
            wd_cnt      <= '0;
            link_active <= 1'b1;
        end else begin
            if (sample_tick && !timeout) begin
                wd_cnt <= wd_cnt + 1'b1;
            end
            if (timeout) begin
                link_active <= 1'b0;
            end
        end
    end

    always_ff @(posedge CLK_50Mhz) begin
        if (reset) begin
            drop_count <= '0;
        end else if (refuse && drop_count != 8'hFF) begin
            drop_count <= drop_count + 8'd1;
        end
    end

endmodule

// File: tb/tb_music_voice_scheduler.sv
// Randomised and directed bench for music_voice_scheduler against a timestamp-based
// reference model (each accepted frame is scheduled for its shadow-write edge).
module tb_music_voice_scheduler;

    localparam int NV    = 3;
    localparam int DEPTH = 8;
    localparam int WD    = 4;

    logic                   clk;
    logic                   reset;
    logic                   frame_valid;
    logic [15:0]            frame_data;
    logic                   frame_ready;
    logic                   sample_tick;
    logic [NV-1:0][12:0]    voice_freq;
    logic [NV-1:0][7:0]     voice_amp;
    logic                   update_strobe;
    logic                   link_active;
    logic [7:0]             drop_count;

    music_voice_scheduler #(
        .NUM_VOICES     (NV),
        .FIFO_DEPTH     (DEPTH),
        .WATCHDOG_TICKS (WD)
    ) dut (
        .CLK_50Mhz     (clk),
        .reset         (reset),
        .frame_valid   (frame_valid),
        .frame_data    (frame_data),
        .frame_ready   (frame_ready),
        .sample_tick   (sample_tick),
        .voice_freq    (voice_freq),
        .voice_amp     (voice_amp),
        .update_strobe (update_strobe),
        .link_active   (link_active),
        .drop_count    (drop_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [15:0] data;
        int          wr_edge;
    } pend_t;

    pend_t       pend[$];
    int          cyc = 0;
    int          last_wr = -100;
    logic [12:0] m_sh_freq [NV];
    logic [7:0]  m_sh_amp  [NV];
    logic [12:0] m_freq    [NV];
    logic [7:0]  m_amp     [NV];
    logic        m_strobe;
    logic        m_link;
    int          m_wd;
    int          m_drop;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h (edge %0d)", tag, got, exp, cyc);
        end
    endtask

    // Frames still held in the FIFO before edge n: popped two edges before their write.
    function automatic int occ_at(input int n);
        int c = 0;
        foreach (pend[i]) if (pend[i].wr_edge - 2 >= n) c++;
        return c;
    endfunction

    task automatic model_reset();
        pend.delete();
        last_wr  = -100;
        m_strobe = 1'b0;
        m_link   = 1'b0;
        m_wd     = 0;
        m_drop   = 0;
        for (int v = 0; v < NV; v++) begin
            m_sh_freq[v] = '0;
            m_sh_amp[v]  = '0;
            m_freq[v]    = '0;
            m_amp[v]     = '0;
        end
    endtask

    task automatic model_step();
        int   n;
        logic ready;
        logic acc;
        logic timed;
        int   w;
        int   vi;
        n = cyc;
        if (reset) begin
            model_reset();
        end else begin
            ready = (occ_at(n) < DEPTH);
            acc   = frame_valid && ready;
            timed = (m_wd == WD);
            if (sample_tick) begin
                m_freq = m_sh_freq;
                m_amp  = m_sh_amp;
            end
            m_strobe = sample_tick;
            while (pend.size() > 0 && pend[0].wr_edge == n) begin
                vi = int'(pend[0].data[15:14]);
                if (vi < NV) begin
                    if (pend[0].data[13] == 1'b0) m_sh_freq[vi] = pend[0].data[12:0];
                    else                          m_sh_amp[vi]  = pend[0].data[7:0];
                end
                void'(pend.pop_front());
            end
            if (timed) begin
                for (int v = 0; v < NV; v++) m_sh_amp[v] = '0;
            end
            if (acc) begin
                m_wd   = 0;
                m_link = 1'b1;
            end else begin
                if (sample_tick && !timed) m_wd++;
                if (timed) m_link = 1'b0;
            end
            if (acc) begin
                w = ((n > last_wr) ? n : last_wr) + 3;
                pend.push_back('{data: frame_data, wr_edge: w});
                last_wr = w;
            end else if (frame_valid && m_drop < 255) begin
                m_drop++;
            end
        end
        cyc++;
    endtask

    task automatic check_all();
        check("ready", frame_ready, !reset && (occ_at(cyc) < DEPTH));
        check("strobe", update_strobe, m_strobe);
        check("link", link_active, m_link);
        check("drop", drop_count, m_drop);
        for (int v = 0; v < NV; v++) begin
            check($sformatf("freq%0d", v), voice_freq[v], m_freq[v]);
            check($sformatf("amp%0d", v), voice_amp[v], m_amp[v]);
        end
    endtask

    task automatic cycle(input logic v, input logic [15:0] d, input logic t, input logic r);
        @(negedge clk);
        frame_valid = v;
        frame_data  = d;
        sample_tick = t;
        reset       = r;
        #1;
        if (cyc > 0) check_all();
        @(posedge clk);
        model_step();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 16'h0, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        cycle(1'b0, 16'h0, 1'b0, 1'b1);
        cycle(1'b0, 16'h0, 1'b0, 1'b1);
    endtask

    logic prev_tick;

    initial begin
        frame_valid = 1'b0;
        frame_data  = '0;
        sample_tick = 1'b0;
        reset       = 1'b1;
        model_reset();

        // Reset state, then a single frequency frame committed by a tick five edges later.
        do_reset();
        cycle(1'b1, 16'h0123, 1'b0, 1'b0);
        idle(4);
        cycle(1'b0, 16'h0, 1'b1, 1'b0);
        #2;
        check("t1_freq0", voice_freq[0], 32'h0123);
        check("t1_strobe", update_strobe, 32'h1);

        // Amplitude and frequency for voice 1 land on the same tick.
        cycle(1'b1, 16'h60C8, 1'b0, 1'b0);
        cycle(1'b1, 16'h4ABC, 1'b0, 1'b0);
        idle(8);
        cycle(1'b0, 16'h0, 1'b1, 1'b0);
        #2;
        check("t2_amp1", voice_amp[1], 32'hC8);
        check("t2_freq1", voice_freq[1], 32'h0ABC);

        // Back-to-back burst fills the FIFO and exercises refusal.
        for (int i = 0; i < 30; i++) begin
            cycle(1'b1, {2'(i % 3), 1'b0, 13'(i + 16'h100)}, 1'b0, 1'b0);
        end
        idle(40);
        cycle(1'b0, 16'h0, 1'b1, 1'b0);
        #2;
        check("t3_ready", frame_ready, 32'h1);

        // Shadow write on a tick edge: old value now, new value on the next tick.
        do_reset();
        cycle(1'b1, 16'h9555, 1'b0, 1'b0);
        idle(2);
        cycle(1'b0, 16'h0, 1'b1, 1'b0);
        #2;
        check("t4_old", voice_freq[2], 32'h0);
        idle(2);
        cycle(1'b0, 16'h0, 1'b1, 1'b0);
        #2;
        check("t4_new", voice_freq[2], 32'h1555);

        // Watchdog timeout zeroes amplitude, keeps frequency.
        do_reset();
        cycle(1'b1, 16'h0123, 1'b0, 1'b0);
        cycle(1'b1, 16'h2080, 1'b0, 1'b0);
        idle(6);
        cycle(1'b0, 16'h0, 1'b1, 1'b0);
        #2;
        check("t5_amp", voice_amp[0], 32'h80);
        for (int i = 0; i < 3; i++) begin
            idle(1);
            cycle(1'b0, 16'h0, 1'b1, 1'b0);
        end
        #2;
        check("t5_link_hi", link_active, 32'h1);
        idle(1);
        #2;
        check("t5_link_lo", link_active, 32'h0);
        cycle(1'b0, 16'h0, 1'b1, 1'b0);
        #2;
        check("t5_amp0", voice_amp[0], 32'h0);
        check("t5_freq_kept", voice_freq[0], 32'h0123);

        // Reset right after an accept discards the frame.
        do_reset();
        cycle(1'b1, 16'h0456, 1'b0, 1'b0);
        cycle(1'b0, 16'h0, 1'b1, 1'b1);
        #2;
        check("t6_strobe", update_strobe, 32'h0);
        check("t6_freq0", voice_freq[0], 32'h0);
        idle(6);
        cycle(1'b0, 16'h0, 1'b1, 1'b0);
        #2;
        check("t6_discard", voice_freq[0], 32'h0);

        // Randomised traffic with occasional resets.
        prev_tick = 1'b0;
        for (int i = 0; i < 1500; i++) begin
            logic t;
            t = !prev_tick && ($urandom_range(0, 7) == 0);
            prev_tick = t;
            cycle(1'($urandom_range(0, 1)), 16'($urandom), t, ($urandom_range(0, 299) == 0));
        end

        // Continuous offers drive the drop counter into saturation.
        for (int i = 0; i < 600; i++) begin
            cycle(1'b1, 16'($urandom), ($urandom_range(0, 9) == 0), 1'b0);
        end
        #2;
        check("drop_sat", drop_count, 32'hFF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
